// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and constants for the VC weighted round-robin arbiter
//
// Purpose: scheduler state encoding, default word width and the position of the
//          destination-select bit within a word.
// Ports:   none (package).
package arb_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      SERVE_VC0 = 2'd1,
      SERVE_VC1 = 2'd2
   } arb_state_e;

   localparam int ARB_DATA_W   = 6;
   // The destination select is always the word MSB.
   localparam int ARB_DEST_BIT = ARB_DATA_W - 1;

endpackage

// File: rtl/arb_push_stage.sv
// rtl/arb_push_stage.sv - pop-to-push pipeline stage with destination decode
//
// Purpose: remembers which VC was popped, muxes that FIFO's read data onto the
//          shared push bus one cycle later and steers the push to D0 or D1 by
//          the word MSB. Optional per-destination push counters (ARB_STATS_EN).
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   pop, pop_src        a pop was issued this cycle / which VC (1 = VC1)
//   vc0_data, vc1_data  VC FIFO read data, valid the cycle after the pop
//   inflight            a popped word is on the push bus this cycle
//   d0_push, d1_push    destination pushes
//   d_data              shared push data (zero when nothing is in flight)
//   d0_count, d1_count  wrapping push counters (ARB_STATS_EN only)
module arb_push_stage
   import arb_pkg::*;
#(
   parameter int DATA_W = ARB_DATA_W
`ifdef ARB_STATS_EN
   ,
   parameter int CNT_W  = 8
`endif
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              pop,
   input  logic              pop_src,
   input  logic [DATA_W-1:0] vc0_data,
   input  logic [DATA_W-1:0] vc1_data,
   output logic              inflight,
   output logic              d0_push,
   output logic              d1_push,
   output logic [DATA_W-1:0] d_data
`ifdef ARB_STATS_EN
   ,
   output logic [CNT_W-1:0]  d0_count,
   output logic [CNT_W-1:0]  d1_count
`endif
);

   // Package index is for the default width; shift it if DATA_W is overridden.
   localparam int DEST_BIT = ARB_DEST_BIT + (DATA_W - ARB_DATA_W);

   logic src_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         inflight <= 1'b0;
         src_q    <= 1'b0;
      end else begin
         inflight <= pop;
         if (pop) begin
            src_q <= pop_src;
         end
      end
   end

   // Held at zero between pushes so the bus does not echo stale FIFO data.
   always_comb begin
      d_data = '0;
      if (inflight) begin
         d_data = src_q ? vc1_data : vc0_data;
      end
   end

   assign d0_push = inflight & ~d_data[DEST_BIT];
   assign d1_push = inflight &  d_data[DEST_BIT];

`ifdef ARB_STATS_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         d0_count <= '0;
         d1_count <= '0;
      end else begin
         if (d0_push) begin
            d0_count <= d0_count + 1'b1;
         end
         if (d1_push) begin
            d1_count <= d1_count + 1'b1;
         end
      end
   end
`endif

endmodule

// File: rtl/arbitro_vc_wrr.sv
// rtl/arbitro_vc_wrr.sv - weighted round-robin scheduler from VC0/VC1 FIFOs to D0/D1 FIFOs
//
// Purpose: grants VC0 up to WEIGHT_VC0 and VC1 up to WEIGHT_VC1 consecutive pops
//          per turn, pauses all pops whenever either destination could overflow,
//          and pushes each popped word one cycle later to the destination given
//          by its MSB. Optional push statistics when ARB_STATS_EN is defined.
// Ports:
//   clk, reset                        clock, asynchronous active-high reset
//   vc0_empty, vc1_empty              VC FIFO empty flags
//   vc0_data, vc1_data                VC FIFO read data (cycle after pop)
//   d0_full, d1_full                  destination full flags
//   d0_almost_full, d1_almost_full    destination almost-full flags
//   vc0_pop, vc1_pop                  VC FIFO pops (combinational)
//   d0_push, d1_push, d_data          destination pushes and shared data
//   active_vc                         VC owning the current turn
//   idle                              scheduler is in IDLE
//   d0_count, d1_count                push counters (ARB_STATS_EN only)
module arbitro_vc_wrr
   import arb_pkg::*;
#(
   parameter int DATA_W     = ARB_DATA_W,
   parameter int WEIGHT_VC0 = 4,
   parameter int WEIGHT_VC1 = 1,
   parameter int CNT_W      = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              vc0_empty,
   input  logic              vc1_empty,
   input  logic [DATA_W-1:0] vc0_data,
   input  logic [DATA_W-1:0] vc1_data,
   input  logic              d0_full,
   input  logic              d1_full,
   input  logic              d0_almost_full,
   input  logic              d1_almost_full,
   output logic              vc0_pop,
   output logic              vc1_pop,
   output logic              d0_push,
   output logic              d1_push,
   output logic [DATA_W-1:0] d_data,
   output logic              active_vc,
   output logic              idle
`ifdef ARB_STATS_EN
   ,
   output logic [CNT_W-1:0]  d0_count,
   output logic [CNT_W-1:0]  d1_count
`endif
);

   localparam logic [CNT_W-1:0] W0 = CNT_W'(WEIGHT_VC0);
   localparam logic [CNT_W-1:0] W1 = CNT_W'(WEIGHT_VC1);

   arb_state_e       state, state_nx;
   logic [CNT_W-1:0] wcnt, wcnt_nx, wcnt_inc;
   logic             inflight;
   logic             pause;

   // The destination of a word is unknown until it is read, so an almost-full
   // on either side blocks the pop that would follow an in-flight word.
   assign pause    = d0_full | d1_full | (inflight & (d0_almost_full | d1_almost_full));
   assign wcnt_inc = wcnt + 1'b1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         wcnt  <= '0;
      end else begin
         state <= state_nx;
         wcnt  <= wcnt_nx;
      end
   end

   always_comb begin
      state_nx = state;
      wcnt_nx  = wcnt;
      vc0_pop  = 1'b0;
      vc1_pop  = 1'b0;
      case (state)
         IDLE: begin
            if (!vc0_empty) begin
               state_nx = SERVE_VC0;
            end else if (!vc1_empty) begin
               state_nx = SERVE_VC1;
            end
         end
         SERVE_VC0: begin
            if (!pause) begin
               if (!vc0_empty) begin
                  vc0_pop = 1'b1;
                  if (wcnt_inc == W0) begin
                     wcnt_nx = '0;
                     if (!vc1_empty) begin
                        state_nx = SERVE_VC1;
                     end
                  end else begin
                     wcnt_nx = wcnt_inc;
                  end
               end else if (!vc1_empty) begin
                  state_nx = SERVE_VC1;
                  wcnt_nx  = '0;
               end else begin
                  state_nx = IDLE;
                  wcnt_nx  = '0;
               end
            end
         end
         SERVE_VC1: begin
            if (!pause) begin
               if (!vc1_empty) begin
                  vc1_pop = 1'b1;
                  if (wcnt_inc == W1) begin
                     wcnt_nx = '0;
                     if (!vc0_empty) begin
                        state_nx = SERVE_VC0;
                     end
                  end else begin
                     wcnt_nx = wcnt_inc;
                  end
               end else if (!vc0_empty) begin
                  state_nx = SERVE_VC0;
                  wcnt_nx  = '0;
               end else begin
                  state_nx = IDLE;
                  wcnt_nx  = '0;
               end
            end
         end
         default: begin
            state_nx = IDLE;
            wcnt_nx  = '0;
         end
      endcase
   end

   assign active_vc = (state == SERVE_VC1);
   assign idle      = (state == IDLE);

   arb_push_stage #(
      .DATA_W (DATA_W)
`ifdef ARB_STATS_EN
      ,
      .CNT_W  (CNT_W)
`endif
   ) u_push (
      .clk      (clk),
      .reset    (reset),
      .pop      (vc0_pop | vc1_pop),
      .pop_src  (vc1_pop),
      .vc0_data (vc0_data),
      .vc1_data (vc1_data),
      .inflight (inflight),
      .d0_push  (d0_push),
      .d1_push  (d1_push),
      .d_data   (d_data)
`ifdef ARB_STATS_EN
      ,
      .d0_count (d0_count),
      .d1_count (d1_count)
`endif
   );

endmodule

// File: tb/tb_arbitro_vc_wrr.sv
// tb/tb_arbitro_vc_wrr.sv - self-checking bench for arbitro_vc_wrr
module tb_arbitro_vc_wrr;

   localparam int DW = 6;
   localparam int W0 = 4;
   localparam int W1 = 1;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          vc0_empty, vc1_empty;
   logic [DW-1:0] vc0_data, vc1_data;
   logic          d0_full, d1_full, d0_almost_full, d1_almost_full;
   logic          vc0_pop, vc1_pop, d0_push, d1_push, active_vc, idle;
   logic [DW-1:0] d_data;
`ifdef ARB_STATS_EN
   logic [CW-1:0] d0_count, d1_count;
`endif

   always #5 clk = ~clk;

   arbitro_vc_wrr #(
      .DATA_W     (DW),
      .WEIGHT_VC0 (W0),
      .WEIGHT_VC1 (W1),
      .CNT_W      (CW)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .vc0_empty      (vc0_empty),
      .vc1_empty      (vc1_empty),
      .vc0_data       (vc0_data),
      .vc1_data       (vc1_data),
      .d0_full        (d0_full),
      .d1_full        (d1_full),
      .d0_almost_full (d0_almost_full),
      .d1_almost_full (d1_almost_full),
      .vc0_pop        (vc0_pop),
      .vc1_pop        (vc1_pop),
      .d0_push        (d0_push),
      .d1_push        (d1_push),
      .d_data         (d_data),
      .active_vc      (active_vc),
      .idle           (idle)
`ifdef ARB_STATS_EN
      ,
      .d0_count       (d0_count),
      .d1_count       (d1_count)
`endif
   );

   int checks = 0;
   int errors = 0;

   // Emulated VC FIFO contents
   logic [DW-1:0] q0[$];
   logic [DW-1:0] q1[$];

   // Reference model: turn owner, pops left in the turn, word in flight
   bit            m_busy = 0;
   bit            m_turn = 0;
   int            m_left = 0;
   bit            m_infl = 0;
   logic [DW-1:0] m_word = '0;
   int            m_c0 = 0;
   int            m_c1 = 0;

   // Observed tallies and pop order
   int n_pop0 = 0, n_pop1 = 0, n_push0 = 0, n_push1 = 0;
   int pop_log[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock cycle: present FIFO flags, compare against the model, then
   // let the emulated FIFOs react to the DUT's pops after the edge.
   task automatic step();
      bit has0, has1, pause_e, e_pop0, e_pop1, mine, theirs, e_d0, e_d1, e_idle, e_act, s0, s1;
      logic [DW-1:0] e_dd;
      @(negedge clk);
      vc0_empty = (q0.size() == 0);
      vc1_empty = (q1.size() == 0);
      #2;
      has0 = !vc0_empty;
      has1 = !vc1_empty;
      if (reset) begin
         m_busy = 0; m_turn = 0; m_left = 0; m_infl = 0; m_c0 = 0; m_c1 = 0;
      end
      e_d0    = m_infl && !m_word[DW-1];
      e_d1    = m_infl &&  m_word[DW-1];
      e_dd    = m_infl ? m_word : '0;
      e_idle  = !m_busy;
      e_act   = m_busy && m_turn;
      pause_e = d0_full || d1_full || (m_infl && (d0_almost_full || d1_almost_full));
      e_pop0  = 0;
      e_pop1  = 0;
      if (!reset) begin
         if (!m_busy) begin
            if (has0) begin
               m_busy = 1; m_turn = 0; m_left = W0;
            end else if (has1) begin
               m_busy = 1; m_turn = 1; m_left = W1;
            end
         end else if (!pause_e) begin
            mine   = m_turn ? has1 : has0;
            theirs = m_turn ? has0 : has1;
            if (mine) begin
               if (m_turn) e_pop1 = 1; else e_pop0 = 1;
               m_left--;
               if (m_left == 0) begin
                  if (theirs) m_turn = !m_turn;
                  m_left = m_turn ? W1 : W0;
               end
            end else if (theirs) begin
               m_turn = !m_turn;
               m_left = m_turn ? W1 : W0;
            end else begin
               m_busy = 0;
            end
         end
      end
      chk("vc0_pop", vc0_pop, e_pop0);
      chk("vc1_pop", vc1_pop, e_pop1);
      chk("d0_push", d0_push, e_d0);
      chk("d1_push", d1_push, e_d1);
      chk("d_data", d_data, e_dd);
      chk("idle", idle, e_idle);
      chk("active_vc", active_vc, e_act);
      chk("push_into_full", (d0_push & d0_full) | (d1_push & d1_full), 0);
`ifdef ARB_STATS_EN
      chk("d0_count", d0_count, m_c0);
      chk("d1_count", d1_count, m_c1);
      m_c0 = (m_c0 + e_d0) % 256;
      m_c1 = (m_c1 + e_d1) % 256;
`endif
      if (e_pop0) m_word = q0[0];
      if (e_pop1) m_word = q1[0];
      m_infl = e_pop0 || e_pop1;
      s0 = vc0_pop;
      s1 = vc1_pop;
      n_pop0  += int'(vc0_pop);
      n_pop1  += int'(vc1_pop);
      n_push0 += int'(d0_push);
      n_push1 += int'(d1_push);
      if (vc0_pop) pop_log.push_back(0);
      if (vc1_pop) pop_log.push_back(1);
      @(posedge clk);
      #1;
      if (s0 && q0.size() > 0) vc0_data = q0.pop_front();
      if (s1 && q1.size() > 0) vc1_data = q1.pop_front();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1);
   end

   initial begin
      logic [DW-1:0] t1 [10];
      int exp2 [16];
      int p, p1, pp;
      t1   = '{6'h01, 6'h21, 6'h02, 6'h3F, 6'h10, 6'h20, 6'h05, 6'h2A, 6'h00, 6'h11};
      exp2 = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1};

      reset = 1'b1; vc0_empty = 1'b1; vc1_empty = 1'b1; vc0_data = '0; vc1_data = '0;
      d0_full = 1'b0; d1_full = 1'b0; d0_almost_full = 1'b0; d1_almost_full = 1'b0;
      step();
      step();
      chk("rst_idle", idle, 1);
      chk("rst_vc0_pop", vc0_pop, 0);
      chk("rst_d_data", d_data, 0);
      chk("rst_active_vc", active_vc, 0);
      reset = 1'b0;

      // Ten VC0 words, four addressed to D1
      n_pop0 = 0; n_push0 = 0; n_push1 = 0;
      foreach (t1[i]) q0.push_back(t1[i]);
      step();
      chk("t1_no_pop_from_idle", n_pop0, 0);
      step();
      chk("t1_first_pop", n_pop0, 1);
      repeat (12) step();
      chk("t1_pops", n_pop0, 10);
      chk("t1_d0_pushes", n_push0, 6);
      chk("t1_d1_pushes", n_push1, 4);
      chk("t1_back_to_idle", idle, 1);

      // Both VCs loaded: 4:1 interleave, then VC1 alone
      pop_log.delete();
      for (int i = 0; i < 12; i++) q0.push_back(DW'(i));
      for (int i = 0; i < 4; i++) q1.push_back(DW'(6'h20 | i));
      repeat (22) step();
      chk("t2_pop_count", pop_log.size(), 16);
      for (int i = 0; i < 16; i++) begin
         if (i < pop_log.size()) chk("t2_pop_order", pop_log[i], exp2[i]);
      end

      // Almost-full with a word in flight, then full
      p = n_pop0;
      for (int i = 0; i < 6; i++) q0.push_back(DW'(i + 1));
      step();
      step();
      chk("t3_first_pop", n_pop0, p + 1);
      d0_almost_full = 1'b1;
      step();
      chk("t3_af_blocks", n_pop0, p + 1);
      d0_almost_full = 1'b0;
      step();
      chk("t3_resume", n_pop0, p + 2);
      d0_almost_full = 1'b1;
      step();
      d0_full = 1'b1;
      repeat (2) step();
      chk("t3_full_blocks", n_pop0, p + 2);
      d0_full = 1'b0;
      d0_almost_full = 1'b0;
      repeat (8) step();
      chk("t3_drained", n_pop0, p + 6);

      // d1_full for three cycles mid-turn: the turn resumes where it left off
      p = n_pop0; p1 = n_pop1;
      for (int i = 0; i < 8; i++) q0.push_back(DW'(i));
      for (int i = 0; i < 2; i++) q1.push_back(DW'(i + 8));
      repeat (3) step();
      chk("t4_two_pops", n_pop0, p + 2);
      d1_full = 1'b1;
      repeat (3) step();
      chk("t4_pause_vc0", n_pop0, p + 2);
      chk("t4_pause_vc1", n_pop1, p1);
      d1_full = 1'b0;
      repeat (2) step();
      chk("t4_rest_of_turn", n_pop0, p + 4);
      chk("t4_no_early_vc1", n_pop1, p1);
      step();
      chk("t4_vc1_turn", n_pop1, p1 + 1);
      repeat (10) step();

      // Reset right after a pop drops the in-flight word
      p = n_pop0; pp = n_push0;
      for (int i = 0; i < 3; i++) q0.push_back(DW'(i + 3));
      step();
      step();
      chk("t5_popped", n_pop0, p + 1);
      reset = 1'b1;
      #1;
      chk("t5_rst_vc0_pop", vc0_pop, 0);
      chk("t5_rst_d0_push", d0_push, 0);
      chk("t5_rst_d1_push", d1_push, 0);
      chk("t5_rst_d_data", d_data, 0);
      chk("t5_rst_idle", idle, 1);
      chk("t5_rst_active_vc", active_vc, 0);
      step();
      reset = 1'b0;
      repeat (6) step();
      chk("t5_pops", n_pop0, p + 3);
      chk("t5_pushes", n_push0, pp + 2);

`ifdef ARB_STATS_EN
      reset = 1'b1;
      step();
      reset = 1'b0;
      for (int i = 0; i < 300; i++) q0.push_back(DW'(i % 32));
      repeat (305) step();
      chk("stats_d0_count", d0_count, 44);
      chk("stats_d1_count", d1_count, 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/arbitro_vc_wrr.md
# arbitro_vc_wrr

Weighted round-robin scheduler for the transmission-layer arbiter. It pops words from the two virtual-channel FIFOs (VC0, VC1) and steers each popped word into one of the two destination FIFOs (D0, D1). The destination is the word's MSB. The block sits between the VC FIFOs and the D FIFOs and owns all pop/push sequencing and backpressure for that path.

## Interface
Parameters:
- DATA_W, 6, word width; bit DATA_W-1 is the destination select (0 → D0, 1 → D1)
- WEIGHT_VC0, 4, consecutive VC0 pops per VC0 turn (≥1)
- WEIGHT_VC1, 1, consecutive VC1 pops per VC1 turn (≥1)
- CNT_W, 8, width of weight and statistics counters

Ports:
- clk  in  1  single clock; all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- vc0_empty, vc1_empty  in  1  VC FIFO empty flags
- vc0_data, vc1_data  in  DATA_W  VC FIFO read data, valid the cycle after the pop
- d0_full, d1_full, d0_almost_full, d1_almost_full  in  1  D FIFO flags
- vc0_pop, vc1_pop  out  1  VC FIFO pops, combinational
- d0_push, d1_push  out  1  D FIFO pushes
- d_data  out  DATA_W  push data, shared by D0 and D1
- active_vc  out  1  VC that owns the current turn
- idle  out  1  high in IDLE state
- d0_count, d1_count  out  CNT_W  pushes per destination (ARB_STATS_EN only)

## Operation
- FSM states: IDLE, SERVE_VC0, SERVE_VC1. Weight counter wcnt counts pops in the current turn.
- Pause: `pause` = d0_full | d1_full | (inflight & (d0_almost_full | d1_almost_full)). `inflight` is the registered pop from the previous cycle. The destination is unknown at pop time, so both D FIFOs gate every pop.
- A pop is issued only when ~pause, and at most one per cycle. vc0_pop and vc1_pop are never both high.
- IDLE:
  - → SERVE_VC0 if ~vc0_empty; else → SERVE_VC1 if ~vc1_empty.
  - On a tie, VC0 wins.
  - No pop is issued in IDLE.
- SERVE_VCx:
  - Pop VCx when ~vcx_empty & ~pause, then increment wcnt.
  - When wcnt reaches WEIGHT_VCx on that pop: clear wcnt and move to SERVE_VCy if VCy is non-empty, else stay and restart the turn.
  - If VCx is empty and VCy is non-empty: switch immediately, clear wcnt, no pop that cycle.
  - If both are empty: go to IDLE.
  - While paused: hold state and wcnt.
- Push stage:
  - src_q (the popped VC) and inflight are registered on each pop.
  - The next cycle, d_data = src_q ? vc1_data : vc0_data.
  - d0_push = inflight & ~d_data[DATA_W-1]; d1_push = inflight & d_data[DATA_W-1].
- The pause rule guarantees no push to a full D FIFO. The bench checks this with an assertion.

## Timing
- Reset values: vc0_pop = vc1_pop = 0, d0_push = d1_push = 0, d_data = 0, active_vc = 0, idle = 1, state = IDLE, wcnt = 0, counters = 0.
- Pop→push latency is exactly 1 cycle. Back-to-back pops give back-to-back pushes.
- IDLE exit costs one cycle. The first pop occurs the cycle after a VC becomes non-empty.
- Pop is Mealy: it reacts the same cycle to empty and full changes.
- Reset asserted mid-operation: any inflight word is dropped (no push). Pops deassert asynchronously.
- Pause takes effect the same cycle. A word already inflight still completes its push.

## Configuration
- ARB_STATS_EN defined:
  - d0_count / d1_count increment on each d0_push / d1_push and wrap at 2^CNT_W.
  - Both cleared by reset.
- ARB_STATS_EN undefined: the counter ports and logic are absent.

## Structure
- Package arb_pkg holds:
  - the state enum (IDLE, SERVE_VC0, SERVE_VC1)
  - the DATA_W default
  - the destination bit index constant
- One sub-module, arb_push_stage: it contains the inflight/src_q registers, the data mux, the destination decode, and the optional stats counters.
- The FSM and pause logic stay in the top module.

## Test plan
- Reset, then vc0_empty = 0 with 10 words, vc1 empty → 10 consecutive vc0_pop; pushes follow 1 cycle later; words with MSB = 1 go to d1_push only.
- Both VCs non-empty, default weights → pop pattern VC0 ×4, VC1 ×1, repeating; active_vc tracks it.
- d0_almost_full = 1 with a pop inflight → no pop the next cycle; pop resumes the cycle after d0_almost_full drops; no push while full.
- d1_full asserted mid-turn for 3 cycles → exactly 3 pop-free cycles; wcnt is held, and the turn resumes with the remaining pops.
- Reset asserted the cycle after a pop → no push occurs; all outputs return to reset values immediately.
- ARB_STATS_EN build, 300 pushes to D0 with CNT_W = 8 → d0_count = 44 (wrapped), d1_count = 0.
